cfu_sched: RTL and testbench

// - Sequences multi-cycle CFU custom instructions between the CPU execute stage and one CFU compute engine.
// - Captures the command, holds the pipeline via stall_o, and runs a req/ack handshake to the engine.
// - Waits for the engine's done pulse, then presents the result for exactly one unstalled cycle.
// - Sits between the core's CFU port (cfu_ctrl_i/src1_i/src2_i) and the engine instance.

---
 rtl/cfu_sched.sv | 146 ++++++++++++++
 tb/tb_cfu_sched.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfu_sched.sv
// cfu_sched: sequences multi-cycle CFU instructions between the execute stage and one compute engine.
// Build macro CFU_TIMEOUT_EN adds an abort counter that forces TIMEOUT_VAL and sets a sticky err_o.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef CFU_CTRL_WIDTH
`define CFU_CTRL_WIDTH 11
`endif
`ifndef CFU_CTRL_IS_CFU
`define CFU_CTRL_IS_CFU 0
`endif

module cfu_sched #(
    parameter int unsigned        TIMEOUT     = 256,
    parameter logic [`XLEN-1:0]   TIMEOUT_VAL = {`XLEN{1'b1}}
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       stall_i,
    input  logic                       valid_i,
    input  logic [`CFU_CTRL_WIDTH-1:0] cfu_ctrl_i,
    input  logic [`XLEN-1:0]           src1_i,
    input  logic [`XLEN-1:0]           src2_i,
    output logic                       stall_o,
    output logic [`XLEN-1:0]           rslt_o,
    output logic                       eng_req_o,
    output logic [2:0]                 eng_funct3_o,
    output logic [6:0]                 eng_funct7_o,
    output logic [`XLEN-1:0]           eng_src1_o,
    output logic [`XLEN-1:0]           eng_src2_o,
    input  logic                       eng_ack_i,
    input  logic                       eng_done_i,
    input  logic [`XLEN-1:0]           eng_rslt_i,
    output logic                       err_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    state_e           state_q;
    logic [`XLEN-1:0] rslt_q;
    logic             req_q;
    logic [2:0]       funct3_q;
    logic [6:0]       funct7_q;
    logic [`XLEN-1:0] src1_q;
    logic [`XLEN-1:0] src2_q;
    logic             err_q;
    logic             cmdValid;
    logic             timeoutHit;

    assign cmdValid = valid_i & cfu_ctrl_i[`CFU_CTRL_IS_CFU] & ~stall_i;

    // Stall is combinational in the command cycle so the instruction never advances before capture.
    assign stall_o      = ((state_q == IDLE) & cmdValid) | (state_q == ISSUE) | (state_q == WAIT);
    assign rslt_o       = rslt_q;
    assign eng_req_o    = req_q;
    assign eng_funct3_o = funct3_q;
    assign eng_funct7_o = funct7_q;
    assign eng_src1_o   = src1_q;
    assign eng_src2_o   = src2_q;
    assign err_o        = err_q;

`ifdef CFU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 256) ? $clog2(TIMEOUT) : 8;

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if ((state_q == IDLE) && cmdValid) begin
            count_q <= '0;
        end else if ((state_q == ISSUE) || (state_q == WAIT)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    // Abort on the edge where the count would reach TIMEOUT-1, giving TIMEOUT stalled cycles in total.
    assign timeoutHit = ((state_q == ISSUE) || (state_q == WAIT)) &&
                        (count_q == CNT_W'(TIMEOUT - 2));
`else
    logic unusedTimeout;
    assign unusedTimeout = ^TIMEOUT;
    assign timeoutHit    = 1'b0;
`endif

    // rslt_q is only non-zero while in DONE; it is loaded on entry and cleared on exit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rslt_q   <= '0;
            req_q    <= 1'b0;
            funct3_q <= '0;
            funct7_q <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmdValid) begin
                        funct3_q <= cfu_ctrl_i[3:1];
                        funct7_q <= cfu_ctrl_i[10:4];
                        src1_q   <= src1_i;
                        src2_q   <= src2_i;
                        req_q    <= 1'b1;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (eng_ack_i && eng_done_i) begin
                        req_q   <= 1'b0;
                        rslt_q  <= eng_rslt_i;
                        state_q <= DONE;
                    end else if (timeoutHit) begin
                        req_q   <= 1'b0;
                        rslt_q  <= TIMEOUT_VAL;
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end else if (eng_ack_i) begin
                        req_q   <= 1'b0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (eng_done_i) begin
                        rslt_q  <= eng_rslt_i;
                        state_q <= DONE;
                    end else if (timeoutHit) begin
                        rslt_q  <= TIMEOUT_VAL;
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (!stall_i) begin
                        rslt_q  <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cfu_sched.sv
// tb_cfu_sched: directed scoreboard bench for cfu_sched; results are queued at issue and popped by a monitor.
// Define CFU_TIMEOUT_EN for both files to exercise the abort path.

module tb_cfu_sched;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        valid_i;
    logic [10:0] cfu_ctrl_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic        stall_o;
    logic [31:0] rslt_o;
    logic        eng_req_o;
    logic [2:0]  eng_funct3_o;
    logic [6:0]  eng_funct7_o;
    logic [31:0] eng_src1_o;
    logic [31:0] eng_src2_o;
    logic        eng_ack_i;
    logic        eng_done_i;
    logic [31:0] eng_rslt_i;
    logic        err_o;

    int checks   = 0;
    int failures = 0;
    logic [31:0] expQ[$];

    cfu_sched #(.TIMEOUT(16), .TIMEOUT_VAL(32'hFFFFFFFF)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .stall_i      (stall_i),
        .valid_i      (valid_i),
        .cfu_ctrl_i   (cfu_ctrl_i),
        .src1_i       (src1_i),
        .src2_i       (src2_i),
        .stall_o      (stall_o),
        .rslt_o       (rslt_o),
        .eng_req_o    (eng_req_o),
        .eng_funct3_o (eng_funct3_o),
        .eng_funct7_o (eng_funct7_o),
        .eng_src1_o   (eng_src1_o),
        .eng_src2_o   (eng_src2_o),
        .eng_ack_i    (eng_ack_i),
        .eng_done_i   (eng_done_i),
        .eng_rslt_i   (eng_rslt_i),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    // Drives one full CFU instruction with a scripted engine and checks stall/req shape along the way.
    task automatic applyStimulus(input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] s1, input logic [31:0] s2,
                                 input int ackDelay, input int doneDelay,
                                 input logic [31:0] res, input int holdCycles);
        int stallCnt = 0;
        int reqCnt   = 0;
        expQ.push_back(res);
        nextCycle();
        valid_i    = 1'b1;
        stall_i    = 1'b0;
        cfu_ctrl_i = {f7, f3, 1'b1};
        src1_i     = s1;
        src2_i     = s2;
        @(negedge clk_i);
        stallCnt += int'(stall_o);
        reqCnt   += int'(eng_req_o);
        for (int i = 0; i <= ackDelay; i++) begin
            nextCycle();
            src1_i     = ~s1;
            src2_i     = ~s2;
            eng_ack_i  = (i == ackDelay);
            eng_done_i = (i == ackDelay) && (doneDelay == 0);
            eng_rslt_i = eng_done_i ? res : 32'hDEADBEEF;
            @(negedge clk_i);
            stallCnt += int'(stall_o);
            reqCnt   += int'(eng_req_o);
            checkOutput("src1_stable", eng_src1_o, s1);
            checkOutput("src2_stable", eng_src2_o, s2);
            checkOutput("funct_latched", {22'd0, eng_funct7_o, eng_funct3_o}, {22'd0, f7, f3});
        end
        for (int j = 1; j <= doneDelay; j++) begin
            nextCycle();
            eng_ack_i  = 1'b0;
            eng_done_i = (j == doneDelay);
            eng_rslt_i = eng_done_i ? res : 32'hDEADBEEF;
            stall_i    = j[0];
            @(negedge clk_i);
            stallCnt += int'(stall_o);
            reqCnt   += int'(eng_req_o);
        end
        nextCycle();
        eng_ack_i  = 1'b0;
        eng_done_i = 1'b0;
        eng_rslt_i = 32'hDEADBEEF;
        for (int h = 0; h < holdCycles; h++) begin
            stall_i = 1'b1;
            @(negedge clk_i);
            checkOutput("hold_rslt", rslt_o, res);
            checkOutput("hold_stall", {31'd0, stall_o}, 32'd0);
            checkOutput("hold_no_req", {31'd0, eng_req_o}, 32'd0);
            nextCycle();
        end
        stall_i = 1'b0;
        @(negedge clk_i);
        checkOutput("done_rslt", rslt_o, res);
        reqCnt += int'(eng_req_o);
        nextCycle();
        valid_i    = 1'b0;
        cfu_ctrl_i = '0;
        @(negedge clk_i);
        checkOutput("idle_stall", {31'd0, stall_o}, 32'd0);
        checkOutput("idle_rslt", rslt_o, 32'd0);
        checkOutput("stall_cycles", stallCnt, 2 + ackDelay + doneDelay);
        checkOutput("req_cycles", reqCnt, ackDelay + 1);
    endtask

    // Monitor: a stalled-to-unstalled transition outside reset is a DONE presentation.
    initial begin
        logic        prevStall;
        logic        prevRst;
        logic [31:0] exp;
        prevStall = 1'b0;
        prevRst   = 1'b1;
        forever begin
            @(negedge clk_i);
            if (!rst_i && !prevRst && prevStall && !stall_o) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_result: got 0x%08h expected no result", rslt_o);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("scoreboard_rslt", rslt_o, exp);
                end
            end
            prevStall = stall_o;
            prevRst   = rst_i;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_i      = 1'b1;
        stall_i    = 1'b0;
        valid_i    = 1'b0;
        cfu_ctrl_i = '0;
        src1_i     = '0;
        src2_i     = '0;
        eng_ack_i  = 1'b0;
        eng_done_i = 1'b0;
        eng_rslt_i = '0;
        repeat (2) nextCycle();
        rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("reset_stall", {31'd0, stall_o}, 32'd0);
        checkOutput("reset_rslt", rslt_o, 32'd0);
        checkOutput("reset_req", {31'd0, eng_req_o}, 32'd0);
        checkOutput("reset_src1", eng_src1_o, 32'd0);
        checkOutput("reset_funct", {22'd0, eng_funct7_o, eng_funct3_o}, 32'd0);
        checkOutput("reset_err", {31'd0, err_o}, 32'd0);

        applyStimulus(3'd1, 7'h01, 32'd5, 32'd7, 0, 0, 32'd12, 0);
        applyStimulus(3'd5, 7'h2A, 32'h11112222, 32'h33334444, 2, 10, 32'hA5A5A5A5, 0);
        applyStimulus(3'd2, 7'h7F, 32'd9, 32'd10, 1, 2, 32'h00000013, 4);
        applyStimulus(3'd7, 7'h00, 32'hFFFFFFFF, 32'h0, 0, 3, 32'h00000000, 1);

        // Non-CFU instruction, then a CFU instruction blocked by an external stall.
        for (int k = 0; k < 3; k++) begin
            nextCycle();
            valid_i    = 1'b1;
            cfu_ctrl_i = 11'h7FE;
            @(negedge clk_i);
            checkOutput("noncfu_stall", {31'd0, stall_o}, 32'd0);
            checkOutput("noncfu_req", {31'd0, eng_req_o}, 32'd0);
        end
        nextCycle();
        cfu_ctrl_i = 11'h003;
        stall_i    = 1'b1;
        @(negedge clk_i);
        checkOutput("extstall_stall", {31'd0, stall_o}, 32'd0);
        nextCycle();
        valid_i = 1'b0;
        stall_i = 1'b0;
        @(negedge clk_i);
        checkOutput("extstall_req", {31'd0, eng_req_o}, 32'd0);

        // Reset in WAIT: operation abandoned, later done ignored.
        nextCycle();
        valid_i    = 1'b1;
        cfu_ctrl_i = 11'h013;
        src1_i     = 32'h00000042;
        @(negedge clk_i);
        nextCycle();
        eng_ack_i = 1'b1;
        @(negedge clk_i);
        nextCycle();
        eng_ack_i = 1'b0;
        @(negedge clk_i);
        checkOutput("wait_stall", {31'd0, stall_o}, 32'd1);
        nextCycle();
        rst_i   = 1'b1;
        valid_i = 1'b0;
        @(negedge clk_i);
        nextCycle();
        rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("rstwait_stall", {31'd0, stall_o}, 32'd0);
        checkOutput("rstwait_req", {31'd0, eng_req_o}, 32'd0);
        checkOutput("rstwait_rslt", rslt_o, 32'd0);
        nextCycle();
        eng_done_i = 1'b1;
        eng_rslt_i = 32'h12345678;
        @(negedge clk_i);
        nextCycle();
        eng_done_i = 1'b0;
        @(negedge clk_i);
        checkOutput("late_done_rslt", rslt_o, 32'd0);
        checkOutput("late_done_stall", {31'd0, stall_o}, 32'd0);

`ifdef CFU_TIMEOUT_EN
        begin
            int stallCnt = 0;
            expQ.push_back(32'hFFFFFFFF);
            nextCycle();
            valid_i    = 1'b1;
            cfu_ctrl_i = 11'h005;
            @(negedge clk_i);
            stallCnt += int'(stall_o);
            for (int t = 0; t < 64; t++) begin
                nextCycle();
                @(negedge clk_i);
                if (!stall_o) break;
                stallCnt++;
            end
            checkOutput("timeout_stall_cycles", stallCnt, 16);
            checkOutput("timeout_rslt", rslt_o, 32'hFFFFFFFF);
            checkOutput("timeout_err", {31'd0, err_o}, 32'd1);
            checkOutput("timeout_req", {31'd0, eng_req_o}, 32'd0);
            nextCycle();
            valid_i    = 1'b0;
            eng_done_i = 1'b1;
            @(negedge clk_i);
            nextCycle();
            eng_done_i = 1'b0;
            @(negedge clk_i);
            checkOutput("timeout_err_sticky", {31'd0, err_o}, 32'd1);
            checkOutput("timeout_late_done", rslt_o, 32'd0);
            applyStimulus(3'd3, 7'h11, 32'd1, 32'd2, 0, 0, 32'd3, 0);
            checkOutput("err_still_set", {31'd0, err_o}, 32'd1);
            nextCycle();
            rst_i = 1'b1;
            nextCycle();
            rst_i = 1'b0;
            @(negedge clk_i);
            checkOutput("err_cleared", {31'd0, err_o}, 32'd0);
        end
`else
        checkOutput("err_tied", {31'd0, err_o}, 32'd0);
`endif

        repeat (2) nextCycle();
        checkOutput("queue_drained", expQ.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
